// File: rtl/modexp_engine.sv
// Constant-latency modular exponentiation (msg^exp mod modulus), right-to-left
// square-and-multiply on two bit-serial interleaved modular multipliers.
module modexp_engine #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         running,
   input  logic [W-1:0] msg,
   input  logic [W-1:0] exp,
   input  logic [W-1:0] modulus,
   output logic         over,
   output logic [W-1:0] result
);
   localparam int SW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, PREP, EXP, DONE} state_t;
   state_t state, state_nxt;

   logic [W-1:0]  e, n, r, base;
   logic [W:0]    p1, p2, p1_nxt, p2_nxt, a1;
   logic [SW-1:0] s, i;
   logic          step, last_step, last_bit, op_bit, small_mod;

   // One interleaved step: P = 2P mod N, then add A if the operand bit is set.
   // P, A < N < 2^W, so W+1 bits never overflow.
   function automatic logic [W:0] mstep(input logic [W:0] p, input logic [W:0] a,
                                        input logic [W:0] nn, input logic b);
      logic [W:0] t;
      t = {p[W-1:0], 1'b0};
      if (t >= nn) t = t - nn;
      if (b) begin
         t = t + a;
         if (t >= nn) t = t - nn;
      end
      return t;
   endfunction

   assign small_mod = (modulus < W'(2));
   assign step      = running && (state == PREP || state == EXP);
   assign last_step = (s == SW'(W-1));
   assign last_bit  = (i == SW'(W-1));
   // base holds the raw msg during PREP and the reduced/squared base during EXP
   assign op_bit    = base[SW'(W-1) - s];
   assign a1        = (state == PREP) ? {{W{1'b0}}, 1'b1} : {1'b0, r};
   assign p1_nxt    = mstep(p1, a1, {1'b0, n}, op_bit);
   assign p2_nxt    = mstep(p2, {1'b0, base}, {1'b0, n}, op_bit);
   assign over      = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load)
         state_nxt = small_mod ? DONE : PREP;
      else if (step && last_step) begin
         if (state == PREP)  state_nxt = EXP;
         else if (last_bit)  state_nxt = DONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e      <= '0;
         n      <= '0;
         r      <= '0;
         base   <= '0;
         p1     <= '0;
         p2     <= '0;
         s      <= '0;
         i      <= '0;
         result <= '0;
      end else if (load) begin
         e    <= exp;
         n    <= modulus;
         base <= msg;
         r    <= W'(1);
         s    <= '0;
         i    <= '0;
         p1   <= '0;
         p2   <= '0;
         if (small_mod) result <= '0;
      end else if (step) begin
         if (last_step) begin
            s  <= '0;
            p1 <= '0;
            p2 <= '0;
            if (state == PREP)
               base <= p1_nxt[W-1:0];
            else begin
               if (e[0]) r <= p1_nxt[W-1:0];
               base <= p2_nxt[W-1:0];
               e    <= e >> 1;
               i    <= i + 1'b1;
               if (last_bit) result <= e[0] ? p1_nxt[W-1:0] : r;
            end
         end else begin
            s  <= s + 1'b1;
            p1 <= p1_nxt;
            p2 <= p2_nxt;
         end
      end
   end
endmodule

// File: tb/tb_modexp_engine.sv
// Randomised and directed checks of modexp_engine against a plain-arithmetic
// modular exponentiation model, including latency, stalls, reload and reset.
module tb_modexp_engine;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load = 1'b0;
   logic         running = 1'b1;
   logic [W-1:0] msg = '0, exp = '0, modulus = '0;
   logic         over;
   logic [W-1:0] result;

   int checks = 0;
   int failures = 0;

   modexp_engine #(.W(W)) dut (
      .clk(clk), .reset(reset), .load(load), .running(running),
      .msg(msg), .exp(exp), .modulus(modulus),
      .over(over), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   function automatic longint ref_modexp(input longint m, input longint e, input longint nn);
      longint acc, b, ee;
      if (nn < 2) return 0;
      acc = 1;
      b   = m % nn;
      ee  = e;
      while (ee != 0) begin
         if (ee % 2 == 1) acc = (acc * b) % nn;
         b  = (b * b) % nn;
         ee = ee / 2;
      end
      return acc;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives load during cycle k; returns positioned in cycle k+1.
   task automatic start(input int m, input int e, input int nn);
      msg = W'(m); exp = W'(e); modulus = W'(nn);
      load = 1'b1;
      tick();
      load = 1'b0;
      // scramble operands: they must be ignored outside load
      msg = W'($urandom); exp = W'($urandom); modulus = W'($urandom);
   endtask

   // Latency counted as cycles after the load cycle; -1 on timeout.
   task automatic wait_over(input int stall_at, input int stall_len, output int lat);
      int cnt;
      cnt = 1;
      while (!over && cnt < 2000) begin
         running = !(cnt >= stall_at && cnt < stall_at + stall_len);
         tick();
         cnt++;
      end
      running = 1'b1;
      lat = over ? cnt : -1;
   endtask

   task automatic run_op(input string tag, input int m, input int e, input int nn,
                         input int stall_at, input int stall_len, input int want_lat,
                         input longint want_res);
      int lat;
      start(m, e, nn);
      if (nn >= 2) chk({tag, "_over_low"}, over, 0);
      wait_over(stall_at, stall_len, lat);
      chk({tag, "_lat"}, lat, want_lat);
      chk({tag, "_res"}, result, want_res);
      chk({tag, "_model"}, result, ref_modexp(m, e, nn));
      tick();
      chk({tag, "_hold"}, over, 1);
   endtask

   initial begin
      int m, e, nn;
      longint prev;
      repeat (3) tick();
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("idle_over", over, 0);
         chk("idle_res", result, 0);
      end

      run_op("rsa_enc", 65, 17, 3233, 0, 0, 273, 2790);
      run_op("rsa_dec", 2790, 2753, 3233, 0, 0, 273, 65);
      run_op("base_red", 500, 1, 497, 0, 0, 273, 3);
      run_op("exp_zero", 4, 0, 497, 0, 0, 273, 1);
      run_op("mod_one", 1234, 77, 1, 0, 0, 1, 0);
      run_op("mod_zero", 9, 3, 0, 0, 0, 1, 0);
      run_op("stall", 4, 13, 497, 50, 10, 283, 445);
      run_op("stall_prep", 4, 13, 497, 5, 3, 276, 445);

      // reload mid-operation
      prev = longint'(result);
      start(4, 13, 497);
      for (int c = 1; c < 100; c++) tick();
      chk("reload_busy", over, 0);
      chk("reload_keep", result, prev);
      run_op("reload", 65, 17, 3233, 0, 0, 273, 2790);

      // reset mid-operation
      start(4, 13, 497);
      for (int c = 1; c < 150; c++) tick();
      reset = 1'b0;
      #1;
      chk("rst_over", over, 0);
      chk("rst_res", result, 0);
      tick();
      reset = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      chk("rst_idle", over, 0);

      // reset beats a simultaneous load
      msg = 16'd5; exp = 16'd3; modulus = 16'd1;
      load = 1'b1; reset = 1'b0;
      tick();
      load = 1'b0; reset = 1'b1;
      tick();
      chk("rst_vs_load", over, 0);

      for (int t = 0; t < 10; t++) begin
         m  = int'($urandom_range(0, 65535));
         e  = int'($urandom_range(0, 65535));
         nn = (t % 3 == 0) ? int'($urandom_range(2, 40)) : int'($urandom_range(2, 65535));
         run_op($sformatf("rnd%0d", t), m, e, nn, 0, 0, 273, ref_modexp(m, e, nn));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
